// File: rtl/tcdm_mem_responder.sv
// tcdm_mem_responder: banked, word-interleaved TCDM slave memory with
// per-bank round-robin arbitration and a fixed 1-cycle response.
// Ports: clk, rst (sync, active-high); per-port tcdm_req_i, tcdm_add_i,
//   tcdm_wen_i (1=read), tcdm_be_i, tcdm_data_i in; tcdm_gnt_o (comb),
//   tcdm_r_valid_o, tcdm_r_data_o out; err_cnt_o counts out-of-range hits.
// Optional: define TCDM_MEM_RESPONDER_STALL_EN for LFSR-driven bank stalls
//   (requires NB_BANKS <= 8).
module tcdm_mem_responder #(
  parameter int unsigned NB_PORTS  = 4,
  parameter int unsigned NB_BANKS  = 4,
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] OOR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NB_PORTS-1:0]    tcdm_req_i,
  input  logic [NB_PORTS*32-1:0] tcdm_add_i,
  input  logic [NB_PORTS-1:0]    tcdm_wen_i,
  input  logic [NB_PORTS*4-1:0]  tcdm_be_i,
  input  logic [NB_PORTS*32-1:0] tcdm_data_i,
  output logic [NB_PORTS-1:0]    tcdm_gnt_o,
  output logic [NB_PORTS-1:0]    tcdm_r_valid_o,
  output logic [NB_PORTS*32-1:0] tcdm_r_data_o,
  output logic [15:0]            err_cnt_o
);

  localparam int unsigned ROWS = MEM_WORDS / NB_BANKS;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [31:0] mem_q [NB_BANKS][ROWS];

  logic [PW-1:0] rr_ptr_q [NB_BANKS];
  logic [PW-1:0] rr_ptr_d [NB_BANKS];
  logic [NB_PORTS-1:0] r_valid_q, r_valid_d;
  logic [NB_PORTS*32-1:0] r_data_q, r_data_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [31:0] word_of [NB_PORTS];
  logic [31:0] bank_of [NB_PORTS];
  logic [31:0] row_of  [NB_PORTS];
  logic [NB_PORTS-1:0] oor;

  logic [NB_BANKS-1:0] bank_we;
  logic [RW-1:0] bank_row [NB_BANKS];
  logic [3:0]    bank_be [NB_BANKS];
  logic [31:0]   bank_wdata [NB_BANKS];

  logic [NB_BANKS-1:0] stall;
  logic [NB_PORTS-1:0] gnt;

`ifdef TCDM_MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall = '0;
    for (int b = 0; b < NB_BANKS; b++)
      stall[b] = lfsr_q[b] & lfsr_q[b+8];
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  always_comb stall = '0;
`endif

  // Address decode; out-of-range accesses still map to a bank
  // through the raw word index so they arbitrate normally.
  always_comb begin
    for (int p = 0; p < NB_PORTS; p++) begin
      word_of[p] = (tcdm_add_i[32*p +: 32] - BASE_ADDR) >> 2;
      bank_of[p] = word_of[p] % NB_BANKS;
      row_of[p]  = word_of[p] / NB_BANKS;
      oor[p] = (tcdm_add_i[32*p +: 32] < BASE_ADDR) ||
               (word_of[p] >= MEM_WORDS);
    end
  end

  always_comb begin
    int unsigned idx;
    int unsigned win;
    int unsigned n_oor;
    logic found;
    logic [16:0] sum;
    gnt       = '0;
    r_valid_d = '0;
    r_data_d  = '0;
    bank_we   = '0;
    n_oor     = 0;
    idx       = 0;
    win       = 0;
    found     = 1'b0;
    for (int b = 0; b < NB_BANKS; b++) begin
      rr_ptr_d[b]   = rr_ptr_q[b];
      bank_row[b]   = '0;
      bank_be[b]    = '0;
      bank_wdata[b] = '0;
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NB_PORTS; k++) begin
        idx = (int'(rr_ptr_q[b]) + k) % NB_PORTS;
        if (!found && tcdm_req_i[idx] && bank_of[idx] == 32'(b)) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && !stall[b] && !rst) begin
        gnt[win]       = 1'b1;
        r_valid_d[win] = 1'b1;
        rr_ptr_d[b]    = PW'((win + 1) % NB_PORTS);
        if (oor[win]) begin
          n_oor = n_oor + 1;
          if (tcdm_wen_i[win])
            r_data_d[32*win +: 32] = OOR_RDATA;
        end else if (tcdm_wen_i[win]) begin
          r_data_d[32*win +: 32] = mem_q[b][row_of[win][RW-1:0]];
        end else begin
          bank_we[b]    = 1'b1;
          bank_row[b]   = row_of[win][RW-1:0];
          bank_be[b]    = tcdm_be_i[4*win +: 4];
          bank_wdata[b] = tcdm_data_i[32*win +: 32];
        end
      end
    end
    sum = {1'b0, err_cnt_q} + 17'(n_oor);
    err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB_BANKS; b++) rr_ptr_q[b] <= '0;
      r_valid_q <= '0;
      r_data_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int b = 0; b < NB_BANKS; b++) rr_ptr_q[b] <= rr_ptr_d[b];
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Array is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB_BANKS; b++)
      if (bank_we[b])
        for (int j = 0; j < 4; j++)
          if (bank_be[b][j])
            mem_q[b][bank_row[b]][8*j +: 8] <= bank_wdata[b][8*j +: 8];
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// tb_tcdm_mem_responder: directed self-checking bench for
// tcdm_mem_responder (default build, 4 ports, 4 banks).
module tb_tcdm_mem_responder;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] add;
  logic [3:0]   wen;
  logic [15:0]  be;
  logic [127:0] wdata;
  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [127:0] rdata;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  tcdm_mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .tcdm_req_i     (req),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_gnt_o     (gnt),
    .tcdm_r_valid_o (rvalid),
    .tcdm_r_data_o  (rdata),
    .err_cnt_o      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    req = '0; add = '0; wen = '0; be = '0; wdata = '0;
  endtask

  task automatic drv(input int p, input logic [31:0] a,
                     input logic w, input logic [3:0] b,
                     input logic [31:0] d);
    req[p] = 1'b1;
    add[32*p +: 32] = a;
    wen[p] = w;
    be[4*p +: 4] = b;
    wdata[32*p +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    drv(0, 32'h0, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
    end
    checks++;
    if (rvalid !== 4'b0) begin
      errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid);
    end
    checks++;
    if (rdata !== 128'b0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    checks++;
    if (err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_errcnt: got %h expected 0", err_cnt);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_contention();
    logic [3:0] e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drv(i, 32'h20, 1'b1, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      e = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, e);
      end
      @(negedge clk);
      checks++;
      if (rvalid !== e) begin
        errors++;
        $display("FAIL rr_rvalid[%0d]: got %b expected %b", c, rvalid, e);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drv(0, 32'h10, 1'b0, 4'hF, 32'hCAFEBABE);
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL wr_gnt: got %b expected 0001", gnt);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0001) begin
      errors++; $display("FAIL wr_rvalid: got %b expected 0001", rvalid);
    end
    checks++;
    if (rdata[31:0] !== 32'h0) begin
      errors++; $display("FAIL wr_rdata: got %h expected 0", rdata[31:0]);
    end
    idle();
    drv(1, 32'h10, 1'b1, 4'h0, 32'h0);
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL rd_gnt: got %b expected 0010", gnt);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0010) begin
      errors++; $display("FAIL rd_rvalid: got %b expected 0010", rvalid);
    end
    checks++;
    if (rdata[63:32] !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL rd_data: got %h expected cafebabe", rdata[63:32]);
    end
    idle();
  endtask

  task automatic test_parallel();
    @(negedge clk);
    for (int i = 0; i < 4; i++) drv(i, 32'(4 * i), 1'b1, 4'h0, 32'h0);
    #1;
    checks++;
    if (gnt !== 4'b1111) begin
      errors++; $display("FAIL par_gnt: got %b expected 1111", gnt);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b1111) begin
      errors++; $display("FAIL par_rvalid: got %b expected 1111", rvalid);
    end
    idle();
  endtask

  task automatic test_byte_enable();
    @(negedge clk);
    drv(2, 32'h40, 1'b0, 4'hF, 32'h11223344);
    @(negedge clk);
    drv(2, 32'h40, 1'b0, 4'b0101, 32'hAABBCCDD);
    @(negedge clk);
    drv(2, 32'h40, 1'b0, 4'b0000, 32'hFFFFFFFF);
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0100) begin
      errors++; $display("FAIL be0_rvalid: got %b expected 0100", rvalid);
    end
    drv(2, 32'h40, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (rdata[95:64] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_data: got %h expected 11bb33dd", rdata[95:64]);
    end
    idle();
  endtask

  task automatic test_oor();
    @(negedge clk);
    drv(3, 32'h4000, 1'b1, 4'h0, 32'h0);
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL oor_gnt: got %b expected 1000", gnt);
    end
    @(negedge clk);
    checks++;
    if (rdata[127:96] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oor_rdata: got %h expected deadbeef", rdata[127:96]);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++; $display("FAIL oor_cnt1: got %0d expected 1", err_cnt);
    end
    idle();
    drv(0, 32'h4010, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++; $display("FAIL oor_cnt2: got %0d expected 2", err_cnt);
    end
    idle();
    drv(1, 32'h10, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (rdata[63:32] !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL oor_mem: got %h expected cafebabe", rdata[63:32]);
    end
    idle();
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    drv(1, 32'h10, 1'b1, 4'h0, 32'h0);
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL rst_pre_gnt: got %b expected 0010", gnt);
    end
    #2;
    rst = 1'b1;
    drv(0, 32'h10, 1'b0, 4'hF, 32'h12345678);
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000) begin
      errors++; $display("FAIL rst_rvalid: got %b expected 0000", rvalid);
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_errcnt: got %0d expected 0", err_cnt);
    end
    idle();
    rst = 1'b0;
    drv(1, 32'h10, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (rdata[63:32] !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL rst_keep: got %h expected cafebabe", rdata[63:32]);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_contention();
    test_write_read();
    test_parallel();
    test_byte_enable();
    test_oor();
    test_rst_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
